// File: rtl/clock_pkg.sv
// Shared types, time constants and field encodings for the clock front end.
// Also holds the wrap-around helpers used when editing one field at a time.
package clock_pkg;

  typedef logic [16:0] COUNTER_T;
  typedef logic        FLAG_T;

  typedef struct packed {
    logic [3:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       pm;
  } TIME_T;

  localparam COUNTER_T   COUNTER_MAX   = 17'd86399;
  localparam COUNTER_T   HOUR_TICK     = 17'd3600;
  localparam COUNTER_T   MIN_TICK      = 17'd60;
  localparam COUNTER_T   AMPM_TICK     = 17'd43200;
  localparam logic [3:0] HOUR_ROLLOVER = 4'd12;

  localparam logic [2:0] FIELD_NONE = 3'd0;
  localparam logic [2:0] FIELD_HOUR = 3'd1;
  localparam logic [2:0] FIELD_MIN  = 3'd2;
  localparam logic [2:0] FIELD_SEC  = 3'd3;
  localparam logic [2:0] FIELD_AMPM = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_E_HOUR, S_E_MIN, S_E_SEC, S_E_AMPM, S_COMMIT
  } state_t;

  // 12-hour dial: 12 is followed by 1 and preceded by 11
  function automatic logic [3:0] hour_step(input logic [3:0] h, input logic up);
    if (up) return (h == HOUR_ROLLOVER) ? 4'd1 : h + 4'd1;
    else    return (h == 4'd1) ? HOUR_ROLLOVER : h - 4'd1;
  endfunction

  function automatic logic [5:0] sixty_step(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [2:0] field_of(input state_t s);
    case (s)
      S_E_HOUR: return FIELD_HOUR;
      S_E_MIN:  return FIELD_MIN;
      S_E_SEC:  return FIELD_SEC;
      S_E_AMPM: return FIELD_AMPM;
      default:  return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/entry_m_ts_split.sv
// Splits a seconds-of-day timestamp into 12-hour display fields.
// Purely combinational; midnight and noon both show as hour 12.
module ts_split
  import clock_pkg::*;
(
  input  logic [16:0] ts,
  output TIME_T       t
);

  COUNTER_T hr24;
  COUNTER_T hr12;

  always_comb begin
    hr24   = ts / HOUR_TICK;
    hr12   = hr24 % COUNTER_T'(HOUR_ROLLOVER);
    t.hour = (hr12 == '0) ? HOUR_ROLLOVER : 4'(hr12);
    t.min  = 6'((ts % HOUR_TICK) / MIN_TICK);
    t.sec  = 6'(ts % MIN_TICK);
    t.pm   = (ts >= AMPM_TICK);
  end

endmodule

// File: rtl/entry_m.sv
// Button-driven editor for a 12-hour H:M:S AM/PM value, producing the
// set_time/set_flag pair for the counter and the alarm setpoint/enable.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | waiting for time/alarm edit request; arm_btn toggles
// S_LOAD   | split the captured source timestamp into fields
// S_E_HOUR | editing hour (1..12)
// S_E_MIN  | editing minutes
// S_E_SEC  | editing seconds
// S_E_AMPM | editing AM/PM
// S_COMMIT | alarm target latches ts; time target drops set_flag
module entry_m
  import clock_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [16:0] counter_state,
  input  logic        time_btn,
  input  logic        alrm_btn,
  input  logic        sel_btn,
  input  logic        inc_btn,
  input  logic        dec_btn,
  input  logic        arm_btn,
  output logic        set_flag,
  output logic [16:0] set_time,
  output logic        alarm_flag,
  output logic [16:0] alarm_time,
  output logic [2:0]  edit_field,
  output logic        edit_alarm
);

  state_t   state, state_nxt;
  FLAG_T    target_alarm;
  COUNTER_T src_ts;
  COUNTER_T ts;
  TIME_T    fld;
  TIME_T    split;
  logic     adjust;
  logic [4:0] hour24;

  ts_split u_split (
    .ts (src_ts),
    .t  (split)
  );

  // sel wins over inc/dec; inc and dec together cancel
  assign adjust = ~sel_btn & (inc_btn ^ dec_btn);

  always_comb begin
    hour24 = ((fld.hour == HOUR_ROLLOVER) ? 5'd0 : {1'b0, fld.hour}) +
             (fld.pm ? 5'd12 : 5'd0);
    ts = COUNTER_T'(hour24) * HOUR_TICK + COUNTER_T'(fld.min) * MIN_TICK +
         COUNTER_T'(fld.sec);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (time_btn || alrm_btn) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_E_HOUR;
      S_E_HOUR: if (sel_btn) state_nxt = S_E_MIN;
      S_E_MIN:  if (sel_btn) state_nxt = S_E_SEC;
      S_E_SEC:  if (sel_btn) state_nxt = S_E_AMPM;
      S_E_AMPM: if (sel_btn) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      target_alarm <= 1'b0;
      src_ts       <= '0;
      fld          <= '{hour: HOUR_ROLLOVER, min: 6'd0, sec: 6'd0, pm: 1'b0};
      set_flag     <= 1'b0;
      set_time     <= '0;
      alarm_flag   <= 1'b0;
      alarm_time   <= '0;
      edit_field   <= FIELD_NONE;
      edit_alarm   <= 1'b0;
    end else begin
      edit_field <= field_of(state_nxt);
      edit_alarm <= target_alarm && (field_of(state_nxt) != FIELD_NONE);
      case (state)
        S_IDLE: begin
          if (time_btn) begin
            target_alarm <= 1'b0;
            src_ts       <= counter_state;
          end else if (alrm_btn) begin
            target_alarm <= 1'b1;
            src_ts       <= alarm_time;
          end
          if (arm_btn) alarm_flag <= ~alarm_flag;
        end
        S_LOAD: begin
          fld <= split;
          if (!target_alarm) begin
            set_flag <= 1'b1;
            set_time <= src_ts;
          end
        end
        S_E_HOUR, S_E_MIN, S_E_SEC, S_E_AMPM: begin
          if (adjust) begin
            case (state)
              S_E_HOUR: fld.hour <= hour_step(fld.hour, inc_btn);
              S_E_MIN:  fld.min  <= sixty_step(fld.min, inc_btn);
              S_E_SEC:  fld.sec  <= sixty_step(fld.sec, inc_btn);
              default:  fld.pm   <= ~fld.pm;
            endcase
          end
          if (!target_alarm) set_time <= ts;
        end
        S_COMMIT: begin
          set_flag <= 1'b0;
          if (target_alarm) alarm_time <= ts;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_entry_m.sv
// Self-checking bench for entry_m: directed scenarios plus a randomized run,
// all compared against a behavioural model of the editor.
module tb_entry_m;

  logic        clock = 1'b0;
  logic        reset;
  logic [16:0] counter_state;
  logic        time_btn, alrm_btn, sel_btn, inc_btn, dec_btn, arm_btn;
  logic        set_flag, alarm_flag, edit_alarm;
  logic [16:0] set_time, alarm_time;
  logic [2:0]  edit_field;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [5:0] B_TIME = 6'b000001, B_ALRM = 6'b000010, B_SEL = 6'b000100,
                         B_INC  = 6'b001000, B_DEC  = 6'b010000, B_ARM = 6'b100000;

  entry_m dut (
    .clock(clock), .reset(reset), .counter_state(counter_state),
    .time_btn(time_btn), .alrm_btn(alrm_btn), .sel_btn(sel_btn),
    .inc_btn(inc_btn), .dec_btn(dec_btn), .arm_btn(arm_btn),
    .set_flag(set_flag), .set_time(set_time), .alarm_flag(alarm_flag),
    .alarm_time(alarm_time), .edit_field(edit_field), .edit_alarm(edit_alarm)
  );

  always #5 clock = ~clock;

  // Behavioural model: phase 0 idle, 1 load, 2..5 hour/min/sec/ampm, 6 commit
  int m_phase, m_tgt_alarm, m_src;
  int m_h, m_m, m_s, m_pm;
  int e_sf, e_st, e_af, e_at, e_ef, e_ea;

  wire  [39:0] act = {set_flag, set_time, alarm_flag, alarm_time, edit_field, edit_alarm};
  logic [39:0] exp_v;

  function automatic int hms();
    return ((m_h % 12) + 12 * m_pm) * 3600 + m_m * 60 + m_s;
  endfunction

  task automatic model_edge(input logic rst, input logic [5:0] b);
    int ts_old;
    if (rst) begin
      m_phase = 0; m_tgt_alarm = 0; m_src = 0;
      m_h = 12; m_m = 0; m_s = 0; m_pm = 0;
      e_sf = 0; e_st = 0; e_af = 0; e_at = 0;
    end else if (m_phase == 0) begin
      if (b[0]) begin m_phase = 1; m_tgt_alarm = 0; m_src = int'(counter_state); end
      else if (b[1]) begin m_phase = 1; m_tgt_alarm = 1; m_src = e_at; end
      if (b[5]) e_af = 1 - e_af;
    end else if (m_phase == 1) begin
      m_h = (m_src / 3600) % 12;
      if (m_h == 0) m_h = 12;
      m_m = (m_src / 60) % 60;
      m_s = m_src % 60;
      m_pm = (m_src >= 43200) ? 1 : 0;
      if (m_tgt_alarm == 0) begin e_sf = 1; e_st = m_src; end
      m_phase = 2;
    end else if (m_phase <= 5) begin
      ts_old = hms();
      if (b[2]) m_phase = m_phase + 1;
      else if (b[3] != b[4]) begin
        case (m_phase)
          2: m_h = b[3] ? (m_h % 12) + 1 : ((m_h + 10) % 12) + 1;
          3: m_m = b[3] ? (m_m + 1) % 60 : (m_m + 59) % 60;
          4: m_s = b[3] ? (m_s + 1) % 60 : (m_s + 59) % 60;
          default: m_pm = 1 - m_pm;
        endcase
      end
      if (m_tgt_alarm == 0) e_st = ts_old;
    end else begin
      e_sf = 0;
      if (m_tgt_alarm != 0) e_at = hms();
      m_phase = 0;
    end
    e_ef = (m_phase >= 2 && m_phase <= 5) ? m_phase - 1 : 0;
    e_ea = (e_ef != 0 && m_tgt_alarm != 0) ? 1 : 0;
    exp_v = {e_sf[0], 17'(e_st), e_af[0], 17'(e_at), 3'(e_ef), e_ea[0]};
  endtask

  // Applies one clock edge of stimulus to both the DUT and the model.
  task automatic step(input logic rst, input logic [5:0] b);
    reset = rst;
    {arm_btn, dec_btn, inc_btn, sel_btn, alrm_btn, time_btn} = b;
    model_edge(rst, b);
    @(negedge clock);
    reset = 1'b0;
    {arm_btn, dec_btn, inc_btn, sel_btn, alrm_btn, time_btn} = '0;
  endtask

  task automatic test_reset();
    counter_state = 17'd12345;
    step(1'b1, '0);
    n_checks++;
    if (act !== 40'd0) begin
      n_errors++; $display("FAIL reset_state: got %h expected %h", act, 40'd0);
    end
  endtask

  task automatic test_hour_edit();
    step(1'b1, '0);
    counter_state = 17'd34953;
    step(1'b0, B_TIME);
    step(1'b0, '0);
    n_checks++;
    if (set_flag !== 1'b1 || set_time !== 17'd34953 || edit_field !== 3'd1) begin
      n_errors++; $display("FAIL load_time: got sf=%b st=%0d ef=%0d expected 1 34953 1", set_flag, set_time, edit_field);
    end
    repeat (3) step(1'b0, B_INC);
    step(1'b0, '0);
    n_checks++;
    if (set_time !== 17'd2553 || set_flag !== 1'b1) begin
      n_errors++; $display("FAIL hour_inc_12am: got sf=%b st=%0d expected 1 2553", set_flag, set_time);
    end
    repeat (4) step(1'b0, B_SEL);
    n_checks++;
    if (act !== exp_v || set_flag !== 1'b1 || edit_field !== 3'd0) begin
      n_errors++; $display("FAIL commit_cycle: got %h expected %h", act, exp_v);
    end
    step(1'b0, '0);
    n_checks++;
    if (set_flag !== 1'b0 || set_time !== 17'd2553) begin
      n_errors++; $display("FAIL time_exit: got sf=%b st=%0d expected 0 2553", set_flag, set_time);
    end
  endtask

  task automatic test_alarm_entry();
    step(1'b1, '0);
    step(1'b0, B_ALRM);
    step(1'b0, '0);
    n_checks++;
    if (edit_alarm !== 1'b1 || set_flag !== 1'b0 || edit_field !== 3'd1) begin
      n_errors++; $display("FAIL alarm_load: got ea=%b sf=%b ef=%0d expected 1 0 1", edit_alarm, set_flag, edit_field);
    end
    repeat (2) step(1'b0, B_INC);
    step(1'b0, B_SEL);
    repeat (8) step(1'b0, B_INC);
    step(1'b0, B_SEL);
    repeat (15) step(1'b0, B_DEC);
    step(1'b0, B_SEL);
    step(1'b0, B_DEC);
    step(1'b0, B_SEL);
    n_checks++;
    if (alarm_time !== 17'd0 || act !== exp_v) begin
      n_errors++; $display("FAIL alarm_hold: got at=%0d vec=%h expected 0 %h", alarm_time, act, exp_v);
    end
    step(1'b0, '0);
    n_checks++;
    if (alarm_time !== 17'd50925 || alarm_flag !== 1'b0) begin
      n_errors++; $display("FAIL alarm_commit: got at=%0d af=%b expected 50925 0", alarm_time, alarm_flag);
    end
    step(1'b0, B_ARM);
    n_checks++;
    if (alarm_flag !== 1'b1 || act !== exp_v) begin
      n_errors++; $display("FAIL arm_toggle: got %h expected %h", act, exp_v);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, '0);
    counter_state = 17'd86399;
    step(1'b0, B_TIME);
    step(1'b0, '0);
    step(1'b0, B_SEL);
    step(1'b0, B_SEL);
    step(1'b0, B_INC);
    step(1'b0, '0);
    n_checks++;
    if (set_time !== 17'd86340) begin
      n_errors++; $display("FAIL sec_wrap: got %0d expected 86340", set_time);
    end
    step(1'b1, '0);
    counter_state = 17'd3600;
    step(1'b0, B_TIME);
    step(1'b0, '0);
    step(1'b0, B_DEC);
    step(1'b0, '0);
    n_checks++;
    if (set_time !== 17'd0) begin
      n_errors++; $display("FAIL hour_dec_wrap: got %0d expected 0", set_time);
    end
    step(1'b0, B_SEL);
    step(1'b0, B_DEC);
    step(1'b0, '0);
    n_checks++;
    if (set_time !== 17'd3540) begin
      n_errors++; $display("FAIL min_dec_wrap: got %0d expected 3540", set_time);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, '0);
    counter_state = 17'd45000;
    step(1'b0, B_TIME | B_ALRM);
    step(1'b0, '0);
    n_checks++;
    if (edit_alarm !== 1'b0 || set_flag !== 1'b1 || set_time !== 17'd45000) begin
      n_errors++; $display("FAIL time_beats_alarm: got ea=%b sf=%b st=%0d expected 0 1 45000", edit_alarm, set_flag, set_time);
    end
    step(1'b0, B_SEL | B_INC);
    step(1'b0, '0);
    n_checks++;
    if (edit_field !== 3'd2 || set_time !== 17'd45000) begin
      n_errors++; $display("FAIL sel_over_inc: got ef=%0d st=%0d expected 2 45000", edit_field, set_time);
    end
    step(1'b0, B_INC | B_DEC);
    step(1'b0, '0);
    n_checks++;
    if (edit_field !== 3'd2 || set_time !== 17'd45000) begin
      n_errors++; $display("FAIL inc_dec_cancel: got ef=%0d st=%0d expected 2 45000", edit_field, set_time);
    end
  endtask

  task automatic test_ignored();
    step(1'b1, '0);
    counter_state = 17'd600;
    step(1'b0, B_TIME);
    step(1'b0, '0);
    step(1'b0, B_TIME);
    n_checks++;
    if (edit_field !== 3'd1 || act !== exp_v) begin
      n_errors++; $display("FAIL time_btn_ignored: got %h expected %h", act, exp_v);
    end
    step(1'b0, B_SEL);
    step(1'b0, B_SEL);
    step(1'b0, B_ARM);
    n_checks++;
    if (alarm_flag !== 1'b0 || edit_field !== 3'd3) begin
      n_errors++; $display("FAIL arm_ignored: got af=%b ef=%0d expected 0 3", alarm_flag, edit_field);
    end
  endtask

  task automatic test_reset_mid_edit();
    step(1'b1, '0);
    step(1'b0, B_ARM);
    counter_state = 17'd70000;
    step(1'b0, B_TIME);
    step(1'b0, '0);
    step(1'b0, B_SEL);
    step(1'b1, B_INC);
    n_checks++;
    if (act !== 40'd0) begin
      n_errors++; $display("FAIL reset_mid_edit: got %h expected %h", act, 40'd0);
    end
  endtask

  task automatic test_random();
    logic [5:0] b;
    step(1'b1, '0);
    for (int i = 0; i < 1500; i++) begin
      counter_state = 17'($urandom_range(0, 86399));
      b = '0;
      if ($urandom_range(0, 7) == 0) b[0] = 1'b1;
      if ($urandom_range(0, 7) == 0) b[1] = 1'b1;
      if ($urandom_range(0, 5) == 0) b[2] = 1'b1;
      if ($urandom_range(0, 2) == 0) b[3] = 1'b1;
      if ($urandom_range(0, 2) == 0) b[4] = 1'b1;
      if ($urandom_range(0, 4) == 0) b[5] = 1'b1;
      step(($urandom_range(0, 199) == 0), b);
      n_checks++;
      if (act !== exp_v) begin
        n_errors++; $display("FAIL random_step_%0d: got %h expected %h", i, act, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    counter_state = '0;
    {arm_btn, dec_btn, inc_btn, sel_btn, alrm_btn, time_btn} = '0;
    @(negedge clock);
    test_reset();
    test_hour_edit();
    test_alarm_entry();
    test_wrap();
    test_simultaneous();
    test_ignored();
    test_reset_mid_edit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/entry_m.md
Name: entry_m

Overview:
- User-input front end; the inverse of the output formatter.
- Takes debounced button strobes and edits a 12-hour H:M:S AM/PM value, field by field.
- Converts that value back into a seconds-of-day timestamp (0..86399), driving set_flag/set_time to counter_m and alarm_flag/alarm_time to alarm_m.
- Replaces test_m as the source of those four signals in main.

Parameters:
- COUNTER_MAX, 86399, last valid timestamp.
- HOUR_TICK, 3600, seconds per hour.
- MIN_TICK, 60, seconds per minute.
- AMPM_TICK, 43200, seconds per half-day.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- counter_state  in  17  current timestamp from counter_m.
- time_btn  in  1  1-cycle strobe: enter time edit.
- alrm_btn  in  1  1-cycle strobe: enter alarm edit.
- sel_btn  in  1  1-cycle strobe: advance to next field.
- inc_btn  in  1  1-cycle strobe: increment current field.
- dec_btn  in  1  1-cycle strobe: decrement current field.
- arm_btn  in  1  1-cycle strobe: toggle alarm enable.
- set_flag  out  1  high while time edit is active (holds counter).
- set_time  out  17  timestamp for counter_m.
- alarm_flag  out  1  alarm enable.
- alarm_time  out  17  alarm setpoint.
- edit_field  out  3  0=none, 1=hour, 2=min, 3=sec, 4=ampm.
- edit_alarm  out  1  1 when the current edit target is the alarm.

Behaviour:
- Reset (synchronous; wins over every other input, including mid-edit):
  - state=IDLE; set_flag=0, set_time=0, alarm_flag=0, alarm_time=0.
  - edit_field=0, edit_alarm=0; fields hour=12, min=0, sec=0, pm=0.
- States: IDLE, LOAD, E_HOUR, E_MIN, E_SEC, E_AMPM, COMMIT.
- IDLE transitions:
  - time_btn → LOAD with target=time; the source is counter_state sampled that edge.
  - alrm_btn → LOAD with target=alarm; the source is alarm_time.
  - If both are asserted, time_btn wins.
  - arm_btn toggles alarm_flag in IDLE only; it is ignored in all other states.
- LOAD (1 cycle):
  - Split the source into hour12/min/sec/pm: hour=(ts/3600)%12 with 0 shown as 12; pm=ts>=43200.
  - Next state E_HOUR.
  - If target=time, set_flag rises at this edge (visible from E_HOUR onward) and set_time=source.
- Edit states:
  - sel_btn advances HOUR→MIN→SEC→AMPM→COMMIT.
  - sel_btn has priority over inc/dec in the same cycle.
  - inc_btn and dec_btn asserted together: no change.
  - time_btn and alrm_btn are ignored.
- Field wrap rules:
  - Hour inc: 12→1, 11→12. Hour dec: 1→12.
  - Min/sec inc: 59→0. Min/sec dec: 0→59.
  - AMPM: inc or dec toggles pm.
  - Hours never carry into pm; min/sec never carry into hour.
- Conversion: ts = ((hour%12) + 12*pm)*3600 + min*60 + sec.
  - Computed in 17-bit unsigned; the result is always ≤ 86399.
  - Registered, so latency is 1 cycle after a field change.
- Time target:
  - set_time tracks ts every cycle of the edit states.
  - set_flag stays high through E_AMPM and COMMIT.
- Alarm target:
  - alarm_time is unchanged until COMMIT; on COMMIT it is loaded with ts.
  - alarm_flag is not modified by edit.
- COMMIT (1 cycle):
  - Next state IDLE; set_flag=0 from the IDLE cycle onward.
  - set_time holds its final value, so counter_m resumes from it on the next edge.
- edit_field and edit_alarm are registered and reflect the current state; both are 0 in IDLE, LOAD and COMMIT.

Decomposition:
- Shared package clock_pkg holds:
  - COUNTER_T, FLAG_T, TIME_T;
  - COUNTER_MAX, MIN_TICK, HOUR_TICK, AMPM_TICK, HOUR_ROLLOVER;
  - edit_field encodings.
- One combinational sub-module, ts_split (timestamp → hour12/min/sec/pm), used in LOAD. out_m is to adopt it later.
- The hms→timestamp conversion stays inline.

Test Plan:
- Reset mid-edit: reset asserted in E_MIN → next cycle IDLE, set_flag=0, set_time=0, alarm_flag=0, edit_field=0.
- Hour edit with 12 AM: counter_state=34953 (9:42:33 AM), time_btn, then inc ×3 → fields 12:42:33 AM, set_time=2553 one cycle after last inc, set_flag=1; then sel ×4 → set_flag=0, set_time stays 2553.
- Alarm entry: alrm_btn, then set fields to 2:08:45 PM via inc/dec (pm toggled) → alarm_time unchanged until COMMIT, then 50925; arm_btn in IDLE → alarm_flag=1.
- Wrap cases: from 11:59:59 PM (86399), sec inc → :00 with min unchanged, ts=86340; hour dec from 1 → 12; min dec from 0 → 59.
- Simultaneous strobes: sel+inc in E_HOUR → field advances with hour unchanged; inc+dec → no change; time_btn+alrm_btn in IDLE → time target.
- Ignored inputs: arm_btn during E_SEC → alarm_flag unchanged; time_btn during E_HOUR → state unchanged.
